// File: rtl/peripheral_bus.sv
// peripheral_bus: CPU-data-bus responder for the peripheral register window.
// Holds a reloadable 32-bit timer with interrupt, LED and 7-segment output
// registers, a 2-flop synchronised switch input and an optional free-running
// cycle counter.
// Optional feature: define PERIPH_SYSTICK_EN to instantiate the SYSTICK counter
// at index 6; without it index 6 reads 0.
// Register map (word index = addr[4:2]):
//   0 TH, 1 TL, 2 TCON[2:0], 3 LED, 4 SWITCH (read-only), 5 DIGI,
//   6 SYSTICK (read-only, optional), 7 reserved.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led,
    output logic [11:0]      digi,
    output logic             irqout
);

    localparam int         NUM_REGS = 8;
    localparam logic [2:0] IDX_TH   = 3'd0;
    localparam logic [2:0] IDX_TL   = 3'd1;
    localparam logic [2:0] IDX_TCON = 3'd2;
    localparam logic [2:0] IDX_LED  = 3'd3;
    localparam logic [2:0] IDX_SW   = 3'd4;
    localparam logic [2:0] IDX_DIGI = 3'd5;
    localparam logic [2:0] IDX_TICK = 3'd6;
    localparam logic [2:0] IDX_RSVD = 3'd7;

    // ------------------------------------------------------------------
    // Address decode: window is 32 bytes, byte offset bits are don't-care
    // ------------------------------------------------------------------
    logic       hit;
    logic [2:0] index;
    logic       unused_addr_bits;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign index            = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    // One write-select line per register slot
    logic [NUM_REGS-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr && hit && (index == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0]      th_reg,   th_next;
    logic [31:0]      tl_reg,   tl_next;
    logic [2:0]       tcon_reg, tcon_next;
    logic [LED_W-1:0] led_reg,  led_next;
    logic [11:0]      digi_reg, digi_next;
    logic [SW_W-1:0]  sw_meta_reg;
    logic [SW_W-1:0]  sw_sync_reg;
    logic [31:0]      systick_view;

    logic timer_run;
    logic irq_enable;
    logic reload;
    logic reload_set;

    assign timer_run  = tcon_reg[0];
    assign irq_enable = tcon_reg[1];
    // Reload happens instead of wrapping when the counter sits at all-ones
    assign reload     = timer_run && (tl_reg == 32'hFFFF_FFFF);
    assign reload_set = reload && irq_enable;

    // Next-state for timer and output registers; CPU writes override the timer
    always_comb begin
        th_next   = wr_sel[IDX_TH] ? wdata : th_reg;

        tl_next   = tl_reg;
        if (wr_sel[IDX_TL]) begin
            tl_next = wdata;
        end else if (timer_run) begin
            // Reload always uses the current TH, even if TH is written this cycle
            tl_next = reload ? th_reg : (tl_reg + 32'd1);
        end

        // Hardware status set is OR-ed in so a simultaneous software clear
        // cannot lose an interrupt
        if (wr_sel[IDX_TCON]) begin
            tcon_next = {wdata[2] | reload_set, wdata[1:0]};
        end else begin
            tcon_next = {tcon_reg[2] | reload_set, tcon_reg[1:0]};
        end

        led_next  = wr_sel[IDX_LED]  ? wdata[LED_W-1:0] : led_reg;
        digi_next = wr_sel[IDX_DIGI] ? wdata[11:0]      : digi_reg;
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_reg   <= 32'h0;
            tl_reg   <= 32'h0;
            tcon_reg <= 3'h0;
            led_reg  <= '0;
            digi_reg <= 12'h0;
        end else begin
            th_reg   <= th_next;
            tl_reg   <= tl_next;
            tcon_reg <= tcon_next;
            led_reg  <= led_next;
            digi_reg <= digi_next;
        end
    end

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= switch;
            sw_sync_reg <= sw_meta_reg;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_reg;

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_reg <= 32'h0;
        end else begin
            systick_reg <= systick_reg + 32'd1;
        end
    end

    assign systick_view = systick_reg;
`else
    assign systick_view = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Read path: purely combinational, shows pre-write values
    // ------------------------------------------------------------------
    logic [31:0] reg_view [NUM_REGS];

    // Zero-extended view of every register slot
    always_comb begin
        reg_view[IDX_TH]   = th_reg;
        reg_view[IDX_TL]   = tl_reg;
        reg_view[IDX_TCON] = {29'h0, tcon_reg};
        reg_view[IDX_LED]  = 32'(led_reg);
        reg_view[IDX_SW]   = 32'(sw_sync_reg);
        reg_view[IDX_DIGI] = {20'h0, digi_reg};
        reg_view[IDX_TICK] = systick_view;
        reg_view[IDX_RSVD] = 32'h0;
    end

    assign rdata  = (rd && hit) ? reg_view[index] : 32'h0;

    assign led    = led_reg;
    assign digi   = digi_reg;
    // Interrupt comes straight from flops: no bus-to-irq combinational path
    assign irqout = tcon_reg[1] & tcon_reg[2];

endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: self-checking bench for peripheral_bus.
// Directed scenarios (reset, timer reload/irq, clear race, decode, switch sync,
// systick) followed by randomized bus traffic, all compared every cycle
// against a behavioural register-map model.
module tb_peripheral_bus;

    localparam logic [31:0] BASE = 32'h40000000;
`ifdef PERIPH_SYSTICK_EN
    localparam logic [31:0] TICK_DELTA = 32'd10;
`else
    localparam logic [31:0] TICK_DELTA = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    peripheral_bus #(
        .BASE_ADDR (BASE),
        .LED_W     (8),
        .SW_W      (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the register map
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic [7:0]  sw_hist [2];   // [0] sampled at last edge, [1] the edge before (visible)
    logic [31:0] last_rdata;

    function automatic logic [31:0] reg_addr(int idx);
        return BASE + (32'(idx) << 2);
    endfunction

    task automatic model_clear();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
        sw_hist[0] = 0; sw_hist[1] = 0; m_tick = 0;
    endtask

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0: v = m_th;
                3'd1: v = m_tl;
                3'd2: v = {29'h0, m_tcon};
                3'd3: v = {24'h0, m_led};
                3'd4: v = {24'h0, sw_hist[1]};
                3'd5: v = {20'h0, m_digi};
`ifdef PERIPH_SYSTICK_EN
                3'd6: v = m_tick;
`endif
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    // Apply one clock edge worth of register-map rules to the model
    task automatic model_edge();
        logic        hit, wrap, set_status;
        logic [2:0]  idx;
        logic [31:0] tl_after;
        if (reset !== 1'b1) return;
        hit        = (addr[31:5] == BASE[31:5]);
        idx        = addr[4:2];
        wrap       = m_tcon[0] && (m_tl == 32'hFFFFFFFF);
        set_status = wrap && m_tcon[1];
        if (!m_tcon[0])      tl_after = m_tl;
        else if (wrap)       tl_after = m_th;
        else                 tl_after = m_tl + 32'd1;
        if (wr && hit && idx == 3'd2) m_tcon = {wdata[2] | set_status, wdata[1:0]};
        else                          m_tcon[2] = m_tcon[2] | set_status;
        if (wr && hit) begin
            case (idx)
                3'd0: m_th   = wdata;
                3'd1: tl_after = wdata;
                3'd3: m_led  = wdata[7:0];
                3'd5: m_digi = wdata[11:0];
                default: ;
            endcase
        end
        m_tl       = tl_after;
        sw_hist[1] = sw_hist[0];
        sw_hist[0] = switch;
        m_tick     = m_tick + 32'd1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    task automatic compare_outputs();
        check("rdata",  rdata, rd ? model_read(addr) : 32'h0);
        check("led",    {24'h0, led}, {24'h0, m_led});
        check("digi",   {20'h0, digi}, {20'h0, m_digi});
        check("irqout", {31'h0, irqout}, {31'h0, m_tcon[1] & m_tcon[2]});
        last_rdata = rdata;
    endtask

    // One bus transaction per clock: drive at negedge, compare, then advance model
    task automatic step(input logic r_rst, input logic r_rd, input logic r_wr,
                        input logic [31:0] r_addr, input logic [31:0] r_wdata,
                        input logic [7:0] r_sw);
        @(negedge clk);
        reset = r_rst; rd = r_rd; wr = r_wr; addr = r_addr; wdata = r_wdata; switch = r_sw;
        if (!r_rst) model_clear();
        #1;
        compare_outputs();
        $display("txn t=%0t rst=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h led=%h digi=%h irq=%b",
                 $time, reset, rd, wr, addr, wdata, rdata, led, digi, irqout);
        @(posedge clk);
        model_edge();
    endtask

    task automatic wr_reg(int idx, logic [31:0] d, logic [7:0] s);
        step(1'b1, 1'b0, 1'b1, reg_addr(idx), d, s);
    endtask

    task automatic rd_reg(int idx, logic [7:0] s);
        step(1'b1, 1'b1, 1'b0, reg_addr(idx), 32'h0, s);
    endtask

    initial begin
        logic [31:0] tick0;
        reset = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;
        last_rdata = 0;
        model_clear();
        #3 reset = 1'b0;
        model_clear();

        // ---- T1: reset state, all reads zero after release ----
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, reg_addr(i), 32'h0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, 8'h00);
            if (i != 6) check("T1_read_zero", last_rdata, 32'h0);
        end

        // ---- T6: systick delta over 10 cycles ----
        rd_reg(6, 8'h00);
        tick0 = last_rdata;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        rd_reg(6, 8'h00);
        check("T6_tick_delta", last_rdata - tick0, TICK_DELTA);

        // ---- T2: timer reload and interrupt ----
        wr_reg(0, 32'hFFFFFFFC, 8'h00);
        wr_reg(1, 32'hFFFFFFFE, 8'h00);
        wr_reg(2, 32'h3, 8'h00);
        rd_reg(1, 8'h00); check("T2_tl_fe", last_rdata, 32'hFFFFFFFE);
        rd_reg(1, 8'h00); check("T2_tl_ff", last_rdata, 32'hFFFFFFFF);
        check("T2_irq_before", {31'h0, irqout}, 32'h0);
        rd_reg(2, 8'h00); check("T2_tcon", last_rdata, 32'h7);
        check("T2_irq_after", {31'h0, irqout}, 32'h1);
        rd_reg(1, 8'h00); check("T2_tl_reloaded", last_rdata, 32'hFFFFFFFD);

        // ---- T3: software clear racing the reload ----
        rd_reg(1, 8'h00);                                  // TL=FE
        step(1'b1, 1'b1, 1'b1, reg_addr(2), 32'h3, 8'h00); // TL=FF, clear on reload edge
        check("T3_prewrite_read", last_rdata, 32'h7);
        rd_reg(2, 8'h00); check("T3_tcon_race", last_rdata, 32'h7);
        check("T3_irq_kept", {31'h0, irqout}, 32'h1);
        wr_reg(2, 32'h3, 8'h00);                           // TL=FD: clear sticks
        rd_reg(2, 8'h00); check("T3_tcon_clear", last_rdata, 32'h3);
        check("T3_irq_clear", {31'h0, irqout}, 32'h0);
        wr_reg(2, 32'h0, 8'h00);

        // ---- T4: LED / DIGI / decode ----
        step(1'b1, 1'b0, 1'b1, 32'h4000000C, 32'h1A5, 8'h00);
        step(1'b1, 1'b0, 1'b1, 32'h40000014, 32'hFFF3F, 8'h00);
        check("T4_led", {24'h0, led}, 32'hA5);
        step(1'b1, 1'b0, 1'b1, 32'h4000003C, 32'h1, 8'h00);
        check("T4_digi", {20'h0, digi}, 32'hF3F);
        step(1'b1, 1'b0, 1'b1, 32'h4000001C, 32'h1, 8'h00);
        step(1'b1, 1'b1, 1'b0, 32'h4000003C, 32'h0, 8'h00);
        check("T4_miss_read", last_rdata, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h4000001C, 32'h0, 8'h00);
        check("T4_rsvd_read", last_rdata, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h20000010, 32'h0, 8'h00);
        check("T4_other_region", last_rdata, 32'h0);
        check("T4_led_kept", {24'h0, led}, 32'hA5);

        // ---- T5: switch synchroniser ----
        rd_reg(4, 8'h5A); check("T5_sw_0edge", last_rdata, 32'h0);
        rd_reg(4, 8'h5A); check("T5_sw_1edge", last_rdata, 32'h0);
        rd_reg(4, 8'h5A); check("T5_sw_2edge", last_rdata, 32'h5A);
        wr_reg(4, 32'hFF, 8'h5A);
        rd_reg(4, 8'h5A); check("T5_sw_ro", last_rdata, 32'h5A);

        // ---- T1b: asynchronous reset mid-cycle with pending interrupt ----
        wr_reg(2, 32'h6, 8'h5A);
        rd_reg(2, 8'h5A); check("T1_irq_set", {31'h0, irqout}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("T1_async_led",  {24'h0, led}, 32'h0);
        check("T1_async_digi", {20'h0, digi}, 32'h0);
        check("T1_async_irq",  {31'h0, irqout}, 32'h0);
        model_clear();
        step(1'b0, 1'b1, 1'b0, reg_addr(3), 32'h0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);

        // ---- Randomized traffic ----
        for (int n = 0; n < 600; n++) begin
            int          idx;
            logic [31:0] a, d;
            logic        r, w, rs;
            idx = $urandom_range(0, 7);
            a   = reg_addr(idx) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            d   = $urandom;
            if (idx == 0 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFFF - 32'($urandom_range(0, 4));
            if (idx == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFFF - 32'($urandom_range(0, 6));
            if (idx == 2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 149) != 0);
            step(rs, r, w, a, d, ($urandom_range(0, 9) == 0) ? 8'($urandom) : switch);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
